serv_dbus_ram: RTL and testbench
================================

Name: serv_dbus_ram

Overview:
- Wishbone-classic data-bus responder: the memory end of the core's data bus interface.
- Accepts one word-aligned, byte-lane-selected read or write per cycle request.
- Backs each request with an internal word-wide RAM and returns a single-cycle ack after a programmable number of wait states.
- Used in the core testbench and small SoC builds as the data memory behind the core's load/store unit.

Parameters:
- DEPTH, 256, number of 32-bit words; must be a power of two ≥ 4. AW = log2(DEPTH).
- WAIT_CYCLES, 0, extra cycles inserted between request acceptance and ack; range 0..15.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst_n  input  1  synchronous reset, active-low.
- i_wb_adr  input  32  byte address; only bits [AW+1:2] used.
- i_wb_dat  input  32  write data, already lane-aligned by the initiator.
- i_wb_sel  input  4  byte-lane enables; bit n selects dat[8n+7:8n].
- i_wb_we  input  1  1 = write, 0 = read.
- i_wb_cyc  input  1  request valid; held by the initiator until ack is seen.
- o_wb_rdt  output  32  read data; valid while o_wb_ack = 1 for reads.
- o_wb_ack  output  1  one-cycle completion strobe.

Behaviour:
- Reset (i_rst_n = 0 at a clock edge):
  - state <= IDLE, wait counter <= 0, o_wb_ack <= 0, o_wb_rdt <= 0.
  - RAM contents are not reset.
- Reset overrides every other action at that edge.
- FSM states IDLE, WAIT, ACK.
- IDLE:
  - i_wb_cyc = 1 and WAIT_CYCLES = 0 → perform access, o_wb_ack <= 1, go to ACK.
  - i_wb_cyc = 1 and WAIT_CYCLES > 0 → counter <= WAIT_CYCLES-1, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - i_wb_cyc = 0 → abort: go to IDLE, no RAM write, no ack.
  - Else if counter = 0 → perform access, o_wb_ack <= 1, go to ACK.
  - Else counter decrements.
- ACK:
  - o_wb_ack <= 0 and return to IDLE unconditionally.
  - i_wb_cyc is ignored in this state. The initiator still drives cyc high during the ack cycle and drops it on the following cycle, so there is no back-to-back retrigger.
- Latency: o_wb_ack is high exactly WAIT_CYCLES+1 cycles after the first edge that samples i_wb_cyc = 1 in IDLE.
- Ack is exactly one cycle wide and never high on two consecutive cycles.
- Access, performed at the edge that sets ack:
  - Address, data, sel and we are sampled at that edge, not at acceptance; the initiator holds them stable while cyc = 1.
  - Word index = i_wb_adr[AW+1:2]. Upper address bits are ignored, so the address wraps modulo DEPTH words.
  - Bits [1:0] are ignored; alignment is conveyed by sel.
- Write: each RAM byte n whose sel[n] = 1 takes i_wb_dat[8n+7:8n]; unselected bytes keep their value. o_wb_rdt is unchanged.
- Write with sel = 0000: no RAM change, ack still issued.
- Read: o_wb_rdt <= full 32-bit RAM word regardless of sel. The initiator extracts lanes and sign-extends.
- o_wb_rdt holds its value until the next read completes or reset.
- Read of a location written by the immediately preceding transaction returns the new data; writes commit at the ack edge and the next read access is at least 2 cycles later.
- Reset asserted during WAIT or ACK: transaction dropped, no write performed if not yet at the access edge, ack deasserted at that edge.
- No error response. Misaligned requests are filtered by the initiator, which traps before issuing cyc.

Test Plan:
- WAIT_CYCLES = 0: write adr 0x10, dat 0xDEADBEEF, sel 1111 → ack exactly 1 cycle after cyc sampled. Then read adr 0x10 → rdt 0xDEADBEEF with ack, ack width 1.
- Byte lanes: preload word 0x11223344 at adr 0x20; write dat 0x0000AA00, sel 0010 → subsequent read returns 0x1122AA44. Write sel 1100, dat 0x55660000 → read 0x5566AA44.
- WAIT_CYCLES = 3: read request → ack on 4th cycle after cyc sampled; ack low in between. Hold cyc through the ack cycle → no second ack.
- Abort: WAIT_CYCLES = 3, write 0xCAFEF00D to adr 0x8, drop cyc after 1 cycle → no ack, read of 0x8 returns prior value.
- Address wrap: DEPTH = 256, write 0x12345678 to adr 0x400 → read adr 0x0 returns 0x12345678. Write with sel 0000 → ack issued, data unchanged.
- Reset: assert i_rst_n = 0 mid-WAIT of a write → next edge ack = 0, rdt = 0, state IDLE, target word unchanged. A normal transaction after reset release completes correctly.

Source files
------------

// File: rtl/serv_dbus_ram.sv
// Wishbone-classic data memory for the serv load/store unit.
// Word-wide RAM with byte lanes and a fixed number of wait states per access.
module serv_dbus_ram #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WC_M1 =
    4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nxt;
  logic          access;
  logic [AW-1:0] idx;
  logic [31:0]   mem [DEPTH];
  logic          unused_adr;

  assign idx        = i_wb_adr[AW+1:2];
  assign unused_adr = ^{i_wb_adr[31:AW+2], i_wb_adr[1:0]};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    access    = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_wb_cyc) begin
          if (WAIT_CYCLES == 0) begin
            access    = 1'b1;
            state_nxt = ACK;
          end else begin
            cnt_nxt   = WC_M1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (!i_wb_cyc) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          access    = 1'b1;
          state_nxt = ACK;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ACK: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      o_wb_ack <= 1'b0;
      o_wb_rdt <= 32'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      o_wb_ack <= access;
      if (access && !i_wb_we)
        o_wb_rdt <= mem[idx];
    end
  end

  // RAM has no reset; reset only suppresses a write at its edge
  always_ff @(posedge i_clk) begin
    if (i_rst_n && access && i_wb_we) begin
      for (int n = 0; n < 4; n++) begin
        if (i_wb_sel[n])
          mem[idx][8*n +: 8] <= i_wb_dat[8*n +: 8];
      end
    end
  end

endmodule

// File: tb/tb_serv_dbus_ram.sv
// Bench for serv_dbus_ram: one instance with no wait states, one with three,
// checked against an array model of the memory and the read-data register.
module tb_serv_dbus_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc0;
  logic        cyc3;
  logic [31:0] rdt0;
  logic [31:0] rdt3;
  logic        ack0;
  logic        ack3;

  int total  = 0;
  int passed = 0;

  logic [31:0] mdl [2][256];
  logic [31:0] exp_rdt [2];

  always #5 clk = ~clk;

  serv_dbus_ram #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_wb_adr (adr),
    .i_wb_dat (dat),
    .i_wb_sel (sel),
    .i_wb_we  (we),
    .i_wb_cyc (cyc0),
    .o_wb_rdt (rdt0),
    .o_wb_ack (ack0)
  );

  serv_dbus_ram #(.DEPTH(256), .WAIT_CYCLES(3)) dut3 (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_wb_adr (adr),
    .i_wb_dat (dat),
    .i_wb_sel (sel),
    .i_wb_we  (we),
    .i_wb_cyc (cyc3),
    .o_wb_rdt (rdt3),
    .o_wb_ack (ack3)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic get_ack(input int d);
    return d == 1 ? ack3 : ack0;
  endfunction

  function automatic logic [31:0] get_rdt(input int d);
    return d == 1 ? rdt3 : rdt0;
  endfunction

  // Full request: ack expected on edge W+1 after cyc is first sampled,
  // cyc held through the ack cycle, then dropped.
  task automatic txn(input int d, input logic w, input logic [31:0] a,
                     input logic [31:0] v, input logic [3:0] s);
    int lat;
    int i;
    lat = d == 1 ? 4 : 1;
    i = int'(a[9:2]);
    @(negedge clk);
    adr = a;
    dat = v;
    sel = s;
    we  = w;
    if (d == 1) cyc3 = 1'b1;
    else cyc0 = 1'b1;
    for (int e = 1; e <= lat; e++) begin
      @(posedge clk);
      #1;
      if (e < lat) begin
        check("ack_early", 32'(get_ack(d)), 32'd0);
      end else begin
        check("ack_due", 32'(get_ack(d)), 32'd1);
        if (w) begin
          for (int n = 0; n < 4; n++)
            if (s[n]) mdl[d][i][8*n +: 8] = v[8*n +: 8];
        end else begin
          exp_rdt[d] = mdl[d][i];
        end
        check(w ? "rdt_hold" : "rdt_read", get_rdt(d), exp_rdt[d]);
      end
    end
    @(posedge clk);
    #1;
    check("ack_width", 32'(get_ack(d)), 32'd0);
    @(negedge clk);
    cyc0 = 1'b0;
    cyc3 = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    rst_n = 1'b0;
    adr = '0;
    dat = '0;
    sel = '0;
    we = 1'b0;
    cyc0 = 1'b0;
    cyc3 = 1'b0;
    exp_rdt[0] = '0;
    exp_rdt[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack0", 32'(ack0), 32'd0);
    check("rst_rdt0", rdt0, 32'd0);
    check("rst_ack3", 32'(ack3), 32'd0);
    check("rst_rdt3", rdt3, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 16; k++) begin
      txn(0, 1'b1, 32'(k * 4), $urandom(), 4'hf);
      txn(1, 1'b1, 32'(k * 4), $urandom(), 4'hf);
    end

    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hf);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0);
    check("basic_rd", rdt0, 32'hDEADBEEF);

    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hf);
    txn(0, 1'b1, 32'h20, 32'h0000AA00, 4'b0010);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h1);
    check("lane_b1", rdt0, 32'h1122AA44);
    txn(0, 1'b1, 32'h20, 32'h55660000, 4'b1100);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0);
    check("lane_b23", rdt0, 32'h5566AA44);

    txn(0, 1'b1, 32'h400, 32'h12345678, 4'hf);
    txn(0, 1'b0, 32'h0, 32'h0, 4'hf);
    check("wrap", rdt0, 32'h12345678);
    txn(0, 1'b1, 32'h0, 32'hFFFFFFFF, 4'h0);
    txn(0, 1'b0, 32'h0, 32'h0, 4'hf);
    check("sel_zero", rdt0, 32'h12345678);

    txn(1, 1'b0, 32'h10, 32'h0, 4'hf);

    // Abort: drop cyc after one edge while waiting
    @(negedge clk);
    adr = 32'h8;
    dat = 32'hCAFEF00D;
    sel = 4'hf;
    we = 1'b1;
    cyc3 = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ack0", 32'(ack3), 32'd0);
    @(negedge clk);
    cyc3 = 1'b0;
    for (int e = 0; e < 5; e++) begin
      @(posedge clk);
      #1;
      check("abort_noack", 32'(ack3), 32'd0);
    end
    txn(1, 1'b0, 32'h8, 32'h0, 4'hf);
    check("abort_keep", rdt3, mdl[1][2]);

    // Reset in the middle of a waiting write
    @(negedge clk);
    adr = 32'hC;
    dat = 32'hA5A5A5A5;
    sel = 4'hf;
    we = 1'b1;
    cyc3 = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rstw_ack", 32'(ack3), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_rdt[0] = '0;
    exp_rdt[1] = '0;
    check("rstw_ack3", 32'(ack3), 32'd0);
    check("rstw_rdt3", rdt3, 32'd0);
    check("rstw_rdt0", rdt0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc3 = 1'b0;
    txn(1, 1'b0, 32'hC, 32'h0, 4'hf);
    txn(1, 1'b1, 32'hC, 32'h0BADF00D, 4'hf);
    txn(1, 1'b0, 32'hC, 32'h0, 4'h0);
    check("rstw_after", rdt3, 32'h0BADF00D);

    for (int k = 0; k < 150; k++) begin
      r = $urandom();
      a = {r[31:10], 4'h0, r[9:6], r[1:0]};
      txn(k % 2, r[5], a, $urandom(), r[5:2]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
